// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the 5-stage MIPS pipeline control slice.
// Holds the hazard sequencer state encoding, its default timing parameters,
// the hard-wired zero register index and the opcode/func/ALU-op constants
// used by the main control decoder.
package pipeline_hazard_ctrl_pkg;

  // Hazard sequencer FSM states; the encoding is also exported on state_o
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } hz_state_e;

  localparam int MUL_LAT_DEF     = 4;
  localparam int MEM_TIMEOUT_DEF = 64;

  // $zero is never a real producer, so it can never cause a load-use hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type func field values
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_SLT = 6'h2a;
  localparam logic [5:0] FUNC_MUL = 6'h18;

  // ALU operation select
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_op_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard information and stage control between the pipeline
// datapath and the hazard sequencer.
//   slave  : the sequencer (reads hazard info, drives stage controls)
//   master : the pipeline datapath (drives hazard info, reads controls)
// Hazard info : id_rs_i, id_rt_i, id_uses_rt_i, branch_taken_i,
//               ex_mem_read_i, ex_rt_i, ex_is_mul_i, mem_req_i, mem_ack_i
// Controls    : pc/ifid/idex/exmem write enables, ifid flush, idex/exmem/memwb
//               bubbles, mul_start_o, mem_err_o, state_o (debug)
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_uses_rt_i;
  logic       branch_taken_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rt_i;
  logic       ex_is_mul_i;
  logic       mem_req_i;
  logic       mem_ack_i;

  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_write_o;
  logic       idex_bubble_o;
  logic       exmem_write_o;
  logic       exmem_bubble_o;
  logic       memwb_bubble_o;
  logic       mul_start_o;
  logic       mem_err_o;
  logic [1:0] state_o;

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, branch_taken_i,
    input  ex_mem_read_i, ex_rt_i, ex_is_mul_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
    output exmem_write_o, exmem_bubble_o, memwb_bubble_o,
    output mul_start_o, mem_err_o, state_o
  );

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, branch_taken_i,
    output ex_mem_read_i, ex_rt_i, ex_is_mul_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
    input  exmem_write_o, exmem_bubble_o, memwb_bubble_o,
    input  mul_start_o, mem_err_o, state_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mul_timer.sv
// Tracks how long a MUL has occupied the EX stage.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   ex_is_mul_i      : instruction in EX is a MUL
//   exmem_write_i    : EX/MEM is loading this cycle (the EX instruction moves on)
//   mul_go_o         : a fresh MUL starts this cycle (drives the multiplier start)
//   mul_stall_o      : the MUL must stay in EX for at least one more cycle
//   mul_cnt_o        : remaining occupancy count, for the sequencer FSM
module hazard_mul_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ex_is_mul_i,
  input  logic       exmem_write_i,
  output logic       mul_go_o,
  output logic       mul_stall_o,
  output logic [3:0] mul_cnt_o
);

  localparam bit         MULTI_CYCLE = (MUL_LAT > 1);
  localparam logic [3:0] CNT_LOAD    = 4'(MUL_LAT - 1);

  logic [3:0] mul_cnt_q;
  logic       mul_pend_q;

  // mul_pend blocks re-triggering on the same MUL while it sits in EX; a MUL
  // right behind it is only seen once mul_pend has cleared.
  assign mul_go_o    = ex_is_mul_i & ~mul_pend_q & MULTI_CYCLE;
  assign mul_stall_o = mul_go_o | (mul_pend_q & (mul_cnt_q > 4'd1));
  assign mul_cnt_o   = mul_cnt_q;

  // The counter runs freely once loaded, even while a memory stall freezes
  // EX, so cycles lost to MEM waits also count towards the MUL latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_cnt_q  <= 4'd0;
      mul_pend_q <= 1'b0;
    end else begin
      if (mul_go_o) begin
        mul_cnt_q <= CNT_LOAD;
      end else if (mul_cnt_q != 4'd0) begin
        mul_cnt_q <= mul_cnt_q - 4'd1;
      end

      if (mul_go_o) begin
        mul_pend_q <= 1'b1;
      end else if (exmem_write_i && !mul_stall_o) begin
        mul_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves, highest priority first: data-memory wait (with watchdog), MUL
// occupancy in EX, load-use, and taken branch/jump flush.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   hz           : hazard info in / stage controls out (slave side)
// Parameters:
//   MUL_LAT      : EX cycles a MUL occupies (1..16, 1 = no stall)
//   MEM_TIMEOUT  : max consecutive MEM_WAIT cycles before ERROR (2..255)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = MUL_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] mem_cnt_q, mem_cnt_d;
  logic       mem_err_q;

  logic       mem_stall;
  logic       lu_stall;
  logic       mul_go;
  logic       mul_stall;
  logic [3:0] mul_cnt;

  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic       exmem_write, exmem_bubble, memwb_bubble;

  assign mem_stall = hz.mem_req_i & ~hz.mem_ack_i;

  assign lu_stall = hz.ex_mem_read_i & (hz.ex_rt_i != REG_ZERO) &
                    ((hz.ex_rt_i == hz.id_rs_i) |
                     (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i)));

  hazard_mul_timer #(
    .MUL_LAT(MUL_LAT)
  ) u_mul_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_is_mul_i  (hz.ex_is_mul_i),
    .exmem_write_i(exmem_write),
    .mul_go_o     (mul_go),
    .mul_stall_o  (mul_stall),
    .mul_cnt_o    (mul_cnt)
  );

  // State and watchdog registers; mem_err is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      mem_cnt_q <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      if (state_d == ST_ERROR) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // Next-state logic. The state mainly tracks the memory watchdog and is a
  // debug view; the stall outputs come straight from the stall terms.
  // Leaving MEM_WAIT uses mul_stall so that a MUL still holding EX (or one
  // starting in the release cycle) is reflected as MUL_WAIT.
  always_comb begin
    state_d   = state_q;
    mem_cnt_d = 8'd0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
        end else if (mul_go) begin
          state_d = ST_MUL_WAIT;
        end
      end
      ST_MUL_WAIT: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
        end else if (mul_cnt <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = mul_stall ? ST_MUL_WAIT : ST_RUN;
        end else if (mem_cnt_q == MEM_LAST) begin
          state_d = ST_ERROR;
        end else begin
          mem_cnt_d = mem_cnt_q + 8'd1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // Priority mux for the stage controls. A taken branch only flushes IF/ID
  // when nothing is stalled; otherwise the held branch is seen again once
  // the stall releases.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (rst_i) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state_q == ST_ERROR) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (mul_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (lu_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = hz.branch_taken_i;
    end
  end

  assign hz.pc_write_o     = pc_write;
  assign hz.ifid_write_o   = ifid_write;
  assign hz.ifid_flush_o   = ifid_flush;
  assign hz.idex_write_o   = idex_write;
  assign hz.idex_bubble_o  = idex_bubble;
  assign hz.exmem_write_o  = exmem_write;
  assign hz.exmem_bubble_o = exmem_bubble;
  assign hz.memwb_bubble_o = memwb_bubble;
  // The multiplier runs freely, so its start is not held off by a MEM stall
  assign hz.mul_start_o    = mul_go & ~rst_i & (state_q != ST_ERROR);
  assign hz.mem_err_o      = mem_err_q;
  assign hz.state_o        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MUL_LAT=4,
// MEM_TIMEOUT=8). Control outputs are packed as
// {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_bub}.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] C_RUN   = 8'b1101_0100;
  localparam logic [7:0] C_FLUSH = 8'b1111_0100;
  localparam logic [7:0] C_RST   = 8'b0010_1011;
  localparam logic [7:0] C_MEM   = 8'b0000_0001;
  localparam logic [7:0] C_MUL   = 8'b0000_0110;
  localparam logic [7:0] C_LU    = 8'b0001_1100;
  localparam logic [7:0] C_ERR   = 8'b0000_1011;
  localparam logic [7:0] M_ALL   = 8'hFF;
  localparam logic [7:0] M_NOFL  = 8'b1101_1111;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       exrd;
    logic [4:0] exrt;
    logic       mul;
    logic       req;
    logic       ack;
    logic [7:0] ctl;
    logic       start;
    logic       err;
    logic [1:0] st;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  vec_t vecs[$];

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MUL_LAT    (4),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz   (hz)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string n, input logic r,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic br, input logic rd,
                              input logic [4:0] xrt, input logic m,
                              input logic rq, input logic ak,
                              input logic [7:0] c, input logic s,
                              input logic e, input logic [1:0] st);
    vec_t v;
    v.name = n;  v.rst = r;   v.rs = rs;   v.rt = rt;   v.uses_rt = ur;
    v.br = br;   v.exrd = rd; v.exrt = xrt; v.mul = m;  v.req = rq;
    v.ack = ak;  v.ctl = c;   v.start = s; v.err = e;   v.st = st;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge and let them settle
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst               = v.rst;
    hz.id_rs_i        = v.rs;
    hz.id_rt_i        = v.rt;
    hz.id_uses_rt_i   = v.uses_rt;
    hz.branch_taken_i = v.br;
    hz.ex_mem_read_i  = v.exrd;
    hz.ex_rt_i        = v.exrt;
    hz.ex_is_mul_i    = v.mul;
    hz.mem_req_i      = v.req;
    hz.mem_ack_i      = v.ack;
    #1;
  endtask

  task automatic checkOutput(input string name, input string field,
                             input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got %b expected %b", name, field, act, exp);
    end
  endtask

  task automatic checkRow(input vec_t v, input logic [7:0] mask);
    logic [7:0] ctl;
    ctl = {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_write_o,
           hz.idex_bubble_o, hz.exmem_write_o, hz.exmem_bubble_o,
           hz.memwb_bubble_o};
    checkOutput(v.name, "ctl", ctl & mask, v.ctl & mask);
    checkOutput(v.name, "mul_start", {7'd0, hz.mul_start_o}, {7'd0, v.start});
    checkOutput(v.name, "mem_err", {7'd0, hz.mem_err_o}, {7'd0, v.err});
    checkOutput(v.name, "state", {6'd0, hz.state_o}, {6'd0, v.st});
  endtask

  task automatic step(input vec_t v, input logic [7:0] mask);
    applyStimulus(v);
    checkRow(v, mask);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    hz.id_rs_i = 5'd0;  hz.id_rt_i = 5'd0;  hz.id_uses_rt_i = 1'b0;
    hz.branch_taken_i = 1'b0;  hz.ex_mem_read_i = 1'b0;  hz.ex_rt_i = 5'd0;
    hz.ex_is_mul_i = 1'b0;  hz.mem_req_i = 1'b0;  hz.mem_ack_i = 1'b0;

    //            name            rst rs  rt  ur br rd xrt mul rq ak ctl     st er state
    vecs.push_back(mk("reset0",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,   0, 0, 0));
    vecs.push_back(mk("reset1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,   0, 0, 0));
    vecs.push_back(mk("idle",          0, 1, 2, 1, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("branch",        0, 1, 2, 1, 1, 0, 0, 0, 0, 0, C_FLUSH, 0, 0, 0));
    vecs.push_back(mk("lu_rs",         0, 5, 3, 0, 0, 1, 5, 0, 0, 0, C_LU,    0, 0, 0));
    vecs.push_back(mk("lu_release",    0, 5, 3, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("lu_rt",         0, 1, 7, 1, 0, 1, 7, 0, 0, 0, C_LU,    0, 0, 0));
    vecs.push_back(mk("lu_rt_unused",  0, 1, 7, 0, 0, 1, 7, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("lu_r0",         0, 0, 0, 1, 0, 1, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("lu_branch",     0, 9, 3, 0, 1, 1, 9, 0, 0, 0, C_LU,    0, 0, 0));
    vecs.push_back(mk("br_after_lu",   0, 9, 3, 0, 1, 0, 0, 0, 0, 0, C_FLUSH, 0, 0, 0));
    vecs.push_back(mk("mul_go",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL,   1, 0, 0));
    vecs.push_back(mk("mul_w1",        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL,   0, 0, 1));
    vecs.push_back(mk("mul_w2",        0, 0, 0, 0, 1, 0, 0, 1, 0, 0, C_MUL,   0, 0, 1));
    vecs.push_back(mk("mul_done",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN,   0, 0, 1));
    vecs.push_back(mk("mul_after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("mm_go",         0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL,   1, 0, 0));
    vecs.push_back(mk("mm_s1",         0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   0, 0, 1));
    vecs.push_back(mk("mm_s2",         0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   0, 0, 2));
    vecs.push_back(mk("mm_s3",         0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   0, 0, 2));
    vecs.push_back(mk("mm_s4",         0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   0, 0, 2));
    vecs.push_back(mk("mm_s5",         0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   0, 0, 2));
    vecs.push_back(mk("mm_ack",        0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_RUN,   0, 0, 2));
    vecs.push_back(mk("mm_after",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk("req_ack_same",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN,   0, 0, 0));
    vecs.push_back(mk("mem_over_lu",   0, 4, 0, 0, 1, 1, 4, 0, 1, 0, C_MEM,   0, 0, 0));
    vecs.push_back(mk("lu_after_mem",  0, 4, 0, 0, 1, 1, 4, 0, 1, 1, C_LU,    0, 0, 2));
    vecs.push_back(mk("br_after_mem",  0, 4, 0, 0, 1, 0, 0, 0, 0, 0, C_FLUSH, 0, 0, 0));
    vecs.push_back(mk("mul_in_mem",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   1, 0, 0));
    vecs.push_back(mk("mul_mem_rel",   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_MUL,   0, 0, 2));
    vecs.push_back(mk("mul_mem_w",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL,   0, 0, 1));
    vecs.push_back(mk("mul_mem_done",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN,   0, 0, 1));
    vecs.push_back(mk("mul_mem_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], M_ALL);
    end

    // Reset in the middle of a MUL (mul_cnt=2) must leave nothing behind
    step(mk("rm_go",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL, 1, 0, 0), M_ALL);
    step(mk("rm_w1",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MUL, 0, 0, 1), M_ALL);
    step(mk("rm_rst0",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RST, 0, 0, 1), M_ALL);
    step(mk("rm_rst1",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RST, 0, 0, 0), M_ALL);
    step(mk("rm_rel",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0), M_ALL);
    step(mk("rm_idle",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_FLUSH, 0, 0, 0), M_ALL);

    // Memory watchdog: one RUN stall cycle, then 8 MEM_WAIT cycles, then ERROR
    step(mk("to_enter", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, 0, 0, 0), M_ALL);
    for (int k = 1; k <= 8; k++) begin
      step(mk($sformatf("to_wait%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              C_MEM, 0, 0, 2), M_ALL);
    end
    step(mk("to_error",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ERR, 0, 1, 3), M_NOFL);
    step(mk("late_ack",   0, 0, 0, 0, 1, 0, 0, 1, 1, 1, C_ERR, 0, 1, 3), M_NOFL);
    step(mk("err_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ERR, 0, 1, 3), M_NOFL);
    step(mk("err_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 1, 3), M_ALL);
    step(mk("err_clear",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0), M_ALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It sits beside the general control decoder and drives the per-stage register write enables and bubble inserts, plus the multiplier start strobe. It resolves four hazards in priority order: data-memory wait (with watchdog), multi-cycle MUL occupancy in EX, load-use, and taken branch/jump flush.

Parameters:
MUL_LAT, 4, EX-stage cycles a MUL occupies (legal 1..16; 1 = single-cycle, no stall)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before ERROR (legal 2..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_rs_i  in  5  rs field of instruction in ID
id_rt_i  in  5  rt field of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt as source (R-type, BEQ, SW)
branch_taken_i  in  1  PC mux selects jump/branch target this cycle (J, or BEQ with equal operands)
ex_mem_read_i  in  1  EX instruction is LW (MEM_cs=1, MEM_we=0)
ex_rt_i  in  5  destination rt of EX instruction
ex_is_mul_i  in  1  EX instruction is MUL
mem_req_i  in  1  MEM-stage instruction accesses data memory (MEM_cs)
mem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID loads NOP
idex_write_o  out  1  ID/EX load enable
idex_bubble_o  out  1  ID/EX loads zero control (bubble)
exmem_write_o  out  1  EX/MEM load enable
exmem_bubble_o  out  1  EX/MEM loads zero control
memwb_bubble_o  out  1  MEM/WB loads zero control (MEM/WB always loads)
mul_start_o  out  1  one-cycle multiplier start strobe
mem_err_o  out  1  sticky memory-timeout error
state_o  out  2  FSM state, for debug

Behaviour:
- States: RUN=0, MUL_WAIT=1, MEM_WAIT=2, ERROR=3. Registers: state, mul_cnt[3:0], mul_pend, mem_cnt[7:0].
- Reset (rst_i high at clock edge): state<=RUN, counters<=0, mul_pend<=0, mem_err_o<=0. While rst_i is high, outputs are forced to: all *_write_o=0, all bubbles=1, ifid_flush_o=1, mul_start_o=0.
- Stall terms, evaluated combinationally each cycle:
  - mem_stall = mem_req_i & ~mem_ack_i.
  - mul_go = ex_is_mul_i & ~mul_pend & (MUL_LAT>1).
  - mul_stall = mul_go | (mul_pend & mul_cnt>1).
  - lu_stall = ex_mem_read_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Output priority, highest first:
  - ERROR: every write_o=0, every bubble=1, mem_err_o=1. Only reset leaves ERROR.
  - mem_stall: pc, ifid, idex and exmem write=0; memwb_bubble=1.
  - mul_stall: pc, ifid and idex write=0; exmem_write=1 with exmem_bubble=1.
  - lu_stall: pc and ifid write=0; idex_write=1 with idex_bubble=1. Lasts exactly 1 cycle.
  - Otherwise all writes=1, bubbles=0. ifid_flush_o = branch_taken_i, asserted only in this no-stall case.
- A branch seen during any stall is ignored; it is re-evaluated when the stall releases.
- mul_start_o = mul_go whenever state!=ERROR. Asserted even during mem_stall (the multiplier runs freely).
- At mul_go: mul_cnt<=MUL_LAT-1, mul_pend<=1. mul_cnt decrements every cycle while nonzero, regardless of other stalls.
- mul_pend clears on any cycle where exmem_write_o=1 and mul_stall=0, i.e. when the MUL leaves EX. Total EX occupancy = MUL_LAT cycles (MUL_LAT-1 stall cycles) when no mem_stall overlaps.
- State transitions:
  - RUN -> MEM_WAIT on mem_stall; else RUN -> MUL_WAIT on mul_go.
  - MUL_WAIT -> MEM_WAIT on mem_stall; -> RUN when mul_cnt<=1.
  - MEM_WAIT: mem_cnt increments each cycle. On mem_ack_i: mem_cnt<=0, go to MUL_WAIT if mul_pend & mul_cnt>1, else RUN. If mem_cnt reaches MEM_TIMEOUT-1 without ack -> ERROR.
- A mem_ack_i arriving on the same cycle as mem_req_i causes no stall.
- A new MUL directly behind a retiring MUL is detected the cycle after mul_pend clears.

Decomposition:
- Shared constants header: state encodings (RUN/MUL_WAIT/MEM_WAIT/ERROR), MUL_LAT and MEM_TIMEOUT defaults, and the zero register index; it sits alongside the existing opcode/func/ALU-op constants.
- One sub-module: hazard_mul_timer (mul_cnt, mul_pend, mul_go/mul_stall generation). The FSM, priority mux and watchdog stay in the top.

Test Plan:
- Reset held 2 cycles mid-MUL (mul_cnt=2) -> all writes 0, flush 1 during reset; after release state_o=0, no residual stall, mul_start_o=0.
- LW $5 in EX, ID uses rs=5 -> 1 cycle: pc_write=0, ifid_write=0, idex_bubble=1; next cycle all writes 1. Same case with ex_rt_i=0 -> no stall.
- MUL_LAT=4, ex_is_mul_i high -> mul_start_o for 1 cycle; 3 cycles with exmem_bubble=1 and pc_write=0; 4th cycle all writes 1; no second mul_start_o.
- MUL issued, then mem_req_i=1 with mem_ack_i low for 5 cycles -> memwb_bubble=1 and exmem_write=0 for those 5 cycles, state_o=2; after ack MUL releases with no extra stall (mul_cnt already 0).
- branch_taken_i=1 with lu_stall active -> ifid_flush_o=0 that cycle; next cycle (no stall) ifid_flush_o=1, pc_write=1.
- MEM_TIMEOUT=8, mem_req_i=1, ack never arrives -> state_o=3 after 8 MEM_WAIT cycles, mem_err_o=1 sticky until rst_i; a late mem_ack_i has no effect.
